// File: rtl/tft_bus_engine.sv
// tft_bus_engine: 8080-style panel bus engine with write FIFO, queued read and runtime setup/strobe/hold timing
module tft_bus_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMING_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    input  logic [TIMING_WIDTH-1:0]       i_setup,
    input  logic [TIMING_WIDTH-1:0]       i_strobe,
    input  logic [TIMING_WIDTH-1:0]       i_hold,
    input  logic                          i_wr_stb,
    input  logic                          i_wr_rs,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    output logic                          o_wr_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_wr_count,
    output logic                          o_wr_overflow,
    input  logic                          i_rd_stb,
    input  logic                          i_rd_rs,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_rd_overflow,
    output logic                          o_busy,
    output logic                          o_cmd_finished,
    output logic                          o_cmd_mode,
    output logic                          o_write,
    output logic                          o_read,
    output logic [DATA_WIDTH-1:0]         o_data_out,
    input  logic [DATA_WIDTH-1:0]         i_data_in,
    output logic                          o_data_out_en
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, FINISH} state_t;
    state_t state, state_n;
    logic [TIMING_WIDTH-1:0] cnt, cnt_n, strobe_l, hold_l, strobe_eff;
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic rd_pend, rd_rs, is_rd, is_rd_n, start, start_wr, start_rd, push, last, rd_drop;
    assign o_wr_full  = count == (AW+1)'(FIFO_DEPTH);
    assign o_wr_count = count;
    assign o_busy     = state != IDLE || count != 0 || rd_pend;
    assign push       = i_wr_stb && !o_wr_full;
    assign strobe_eff = i_strobe == 0 ? TIMING_WIDTH'(1) : i_strobe;
    assign last       = cnt == TIMING_WIDTH'(1);
    assign rd_drop    = i_rd_stb && rd_pend && !start_rd;
    always_comb begin
        start    = state == IDLE && i_enable && (count != 0 || rd_pend);
        start_wr = start && count != 0;
        start_rd = start && count == 0;
        is_rd_n  = start ? start_rd : is_rd;
        state_n  = state;
        cnt_n    = cnt;
        case (state)
            IDLE: if (start) begin
                state_n = i_setup != 0 ? SETUP : STROBE;
                cnt_n   = i_setup != 0 ? i_setup : strobe_eff;
            end
            SETUP: begin
                state_n = last ? STROBE : SETUP;
                cnt_n   = last ? strobe_l : cnt - 1'b1;
            end
            STROBE: begin
                state_n = !last ? STROBE : hold_l != 0 ? HOLD : FINISH;
                cnt_n   = last ? hold_l : cnt - 1'b1;
            end
            HOLD: begin
                state_n = last ? FINISH : HOLD;
                cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= {i_wr_rs, i_wr_data};
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            strobe_l       <= '0;
            hold_l         <= '0;
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            rd_pend        <= 1'b0;
            rd_rs          <= 1'b0;
            is_rd          <= 1'b0;
            o_wr_overflow  <= 1'b0;
            o_rd_overflow  <= 1'b0;
            o_rd_data      <= '0;
            o_rd_valid     <= 1'b0;
            o_cmd_finished <= 1'b0;
            o_cmd_mode     <= 1'b0;
            o_write        <= 1'b0;
            o_read         <= 1'b0;
            o_data_out     <= '0;
            o_data_out_en  <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            is_rd          <= is_rd_n;
            wp             <= push ? wp + 1'b1 : wp;
            rp             <= start_wr ? rp + 1'b1 : rp;
            count          <= count + (AW+1)'(push) - (AW+1)'(start_wr);
            o_wr_overflow  <= i_wr_stb && o_wr_full;
            o_rd_overflow  <= rd_drop;
            rd_pend        <= (i_rd_stb && !rd_drop) || (rd_pend && !start_rd);
            rd_rs          <= i_rd_stb && !rd_drop ? i_rd_rs : rd_rs;
            o_write        <= state_n == STROBE && !is_rd_n;
            o_read         <= state_n == STROBE && is_rd_n;
            o_cmd_finished <= state_n == FINISH;
            o_rd_valid     <= state_n == FINISH && is_rd_n;
            if (state == STROBE && last && is_rd) o_rd_data <= i_data_in;
            if (start) begin
                strobe_l      <= strobe_eff;
                hold_l        <= i_hold;
                o_cmd_mode    <= start_wr ? mem[rp][DATA_WIDTH] : rd_rs;
                o_data_out_en <= start_wr;
                o_data_out    <= start_wr ? mem[rp][DATA_WIDTH-1:0] : o_data_out;
            end else if (state == FINISH) begin
                o_data_out_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tft_bus_engine.sv
// tb_tft_bus_engine: directed scenarios for tft_bus_engine, outputs sampled on the falling edge
module tb_tft_bus_engine;
    logic clk = 0, rst = 1, i_enable = 0, i_wr_stb = 0, i_wr_rs = 0, i_rd_stb = 0, i_rd_rs = 0;
    logic [7:0] i_setup = 0, i_strobe = 0, i_hold = 0, i_wr_data = 0, i_data_in = 0;
    logic o_wr_full, o_wr_overflow, o_rd_valid, o_rd_overflow, o_busy, o_cmd_finished;
    logic o_cmd_mode, o_write, o_read, o_data_out_en;
    logic [3:0] o_wr_count;
    logic [7:0] o_rd_data, o_data_out;
    int checks = 0, errors = 0;

    tft_bus_engine dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_setup(i_setup), .i_strobe(i_strobe),
        .i_hold(i_hold), .i_wr_stb(i_wr_stb), .i_wr_rs(i_wr_rs), .i_wr_data(i_wr_data),
        .o_wr_full(o_wr_full), .o_wr_count(o_wr_count), .o_wr_overflow(o_wr_overflow),
        .i_rd_stb(i_rd_stb), .i_rd_rs(i_rd_rs), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_rd_overflow(o_rd_overflow), .o_busy(o_busy), .o_cmd_finished(o_cmd_finished),
        .o_cmd_mode(o_cmd_mode), .o_write(o_write), .o_read(o_read), .o_data_out(o_data_out),
        .i_data_in(i_data_in), .o_data_out_en(o_data_out_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        i_wr_stb = 1; i_wr_rs = rs; i_wr_data = d;
        step();
        i_wr_stb = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        rst = 0;
        checks++; if ({o_write, o_read, o_data_out_en, o_cmd_finished, o_busy, o_wr_full} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {o_write, o_read, o_data_out_en, o_cmd_finished, o_busy, o_wr_full}); end
        checks++; if (o_wr_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_wr_count); end
        checks++; if ({o_rd_data, o_data_out} !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", {o_rd_data, o_data_out}); end
    endtask

    task automatic test_single_write();
        int en_n = 0, wr_n = 0, fin_n = 0, first_wr = -1, fin_at = -1, bad = 0;
        i_enable = 1; i_setup = 1; i_strobe = 2; i_hold = 1;
        push(0, 8'hA5);
        for (int i = 0; i < 12; i++) begin
            if (o_data_out_en) begin en_n++; if (o_data_out !== 8'hA5 || o_cmd_mode !== 1'b0) bad++; end
            if (o_write) begin wr_n++; if (first_wr < 0) first_wr = i; end
            if (o_cmd_finished) begin fin_n++; fin_at = i; end
            if (o_read) bad++;
            step();
        end
        checks++; if (en_n != 5) begin errors++; $display("FAIL single_en_cycles got %0d want 5", en_n); end
        checks++; if (wr_n != 2) begin errors++; $display("FAIL single_wr_cycles got %0d want 2", wr_n); end
        checks++; if (first_wr != 2) begin errors++; $display("FAIL single_wr_start got %0d want 2", first_wr); end
        checks++; if (fin_n != 1 || fin_at != 5) begin errors++; $display("FAIL single_finished got %0d@%0d want 1@5", fin_n, fin_at); end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_bus_data got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        int exp_at [3] = '{1, 4, 7};
        int wr_n = 0, fin_n = 0, bad = 0;
        i_enable = 0; i_setup = 0; i_strobe = 0; i_hold = 0;
        push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
        checks++; if (o_wr_count !== 4'd3) begin errors++; $display("FAIL burst_count0 got %0d want 3", o_wr_count); end
        i_enable = 1;
        for (int i = 0; i < 12; i++) begin
            if (o_write) begin
                if (wr_n > 2 || i != exp_at[wr_n] || o_data_out !== exp_d[wr_n] || o_cmd_mode !== 1'b1
                    || o_wr_count !== 4'(2 - wr_n)) bad++;
                wr_n++;
            end
            if (o_cmd_finished) fin_n++;
            step();
        end
        checks++; if (wr_n != 3) begin errors++; $display("FAIL burst_writes got %0d want 3", wr_n); end
        checks++; if (fin_n != 3) begin errors++; $display("FAIL burst_finished got %0d want 3", fin_n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL burst_sequence got %0d bad strobes want 0", bad); end
    endtask

    task automatic test_full();
        int ovf = 0, wr_n = 0, bad = 0;
        i_enable = 0;
        for (int i = 0; i < 9; i++) begin
            push(0, 8'(8'h40 + i));
            if (o_wr_overflow) ovf++;
        end
        step();
        if (o_wr_overflow) ovf++;
        checks++; if (o_wr_full !== 1'b1 || o_wr_count !== 4'd8) begin errors++; $display("FAIL full_state got full=%b cnt=%0d want 1/8", o_wr_full, o_wr_count); end
        checks++; if (ovf != 1) begin errors++; $display("FAIL full_overflow got %0d want 1", ovf); end
        i_enable = 1;
        for (int i = 0; i < 30; i++) begin
            if (o_write) begin if (o_data_out !== 8'(8'h40 + wr_n)) bad++; wr_n++; end
            step();
        end
        checks++; if (wr_n != 8 || bad != 0) begin errors++; $display("FAIL full_drain got %0d writes %0d bad want 8/0", wr_n, bad); end
        checks++; if (o_busy !== 1'b0 || o_wr_full !== 1'b0) begin errors++; $display("FAIL full_idle got busy=%b full=%b want 0/0", o_busy, o_wr_full); end
    endtask

    task automatic test_read();
        int rd_n = 0, val_n = 0, val_at = -1, bad = 0;
        i_enable = 1; i_setup = 0; i_strobe = 3; i_hold = 0;
        i_rd_stb = 1; i_rd_rs = 1;
        step();
        i_rd_stb = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_read) begin rd_n++; if (o_cmd_mode !== 1'b1) bad++; end
            if (o_write || o_data_out_en) bad++;
            if (o_rd_valid) begin val_n++; val_at = i; if (o_rd_data !== 8'h5C) bad++; end
            i_data_in = i == 3 ? 8'h5C : 8'(8'h10 + i);
            step();
        end
        checks++; if (rd_n != 3) begin errors++; $display("FAIL read_strobe got %0d want 3", rd_n); end
        checks++; if (val_n != 1 || val_at != 4) begin errors++; $display("FAIL read_valid got %0d@%0d want 1@4", val_n, val_at); end
        checks++; if (o_rd_data !== 8'h5C) begin errors++; $display("FAIL read_data got %h want 5c", o_rd_data); end
        checks++; if (bad != 0) begin errors++; $display("FAIL read_bus got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int last_wr = -1, rd_at = -1, wr_n = 0, rd_n = 0;
        logic mode = 0;
        i_enable = 0; i_setup = 0; i_strobe = 0; i_hold = 0; i_data_in = 8'h3C;
        push(0, 8'h71); push(0, 8'h72);
        i_rd_stb = 1; i_rd_rs = 1;
        step();
        i_rd_rs = 0;
        step();
        i_rd_stb = 0;
        checks++; if (o_rd_overflow !== 1'b1) begin errors++; $display("FAIL queued_rd_overflow got %b want 1", o_rd_overflow); end
        step();
        checks++; if (o_rd_overflow !== 1'b0) begin errors++; $display("FAIL queued_rd_overflow_pulse got %b want 0", o_rd_overflow); end
        i_enable = 1;
        for (int i = 0; i < 12; i++) begin
            if (o_write) begin wr_n++; last_wr = i; end
            if (o_read) begin rd_n++; rd_at = i; mode = o_cmd_mode; end
            step();
        end
        checks++; if (wr_n != 2 || rd_n != 1 || rd_at <= last_wr) begin errors++; $display("FAIL queued_order got wr=%0d rd=%0d rd_at=%0d last_wr=%0d want 2/1/after", wr_n, rd_n, rd_at, last_wr); end
        checks++; if (rd_at != 7) begin errors++; $display("FAIL queued_rd_start got %0d want 7", rd_at); end
        checks++; if (mode !== 1'b1) begin errors++; $display("FAIL queued_rd_rs got %b want 1", mode); end
        checks++; if (o_rd_data !== 8'h3C) begin errors++; $display("FAIL queued_rd_data got %h want 3c", o_rd_data); end
    endtask

    task automatic test_reset_mid();
        int fin_n = 0, wr_n = 0;
        i_enable = 0; i_setup = 0; i_strobe = 4; i_hold = 0;
        push(0, 8'h9E); push(0, 8'h9F);
        i_enable = 1;
        step();
        checks++; if (o_write !== 1'b1 || o_wr_count !== 4'd1) begin errors++; $display("FAIL midrst_pre got wr=%b cnt=%0d want 1/1", o_write, o_wr_count); end
        rst = 1;
        step();
        checks++; if (o_write !== 1'b0 || o_data_out_en !== 1'b0 || o_cmd_finished !== 1'b0) begin errors++; $display("FAIL midrst_strobes got wr=%b en=%b fin=%b want 0/0/0", o_write, o_data_out_en, o_cmd_finished); end
        checks++; if (o_wr_count !== 4'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL midrst_fifo got cnt=%0d busy=%b want 0/0", o_wr_count, o_busy); end
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_cmd_finished) fin_n++;
            if (o_write) wr_n++;
            step();
        end
        checks++; if (fin_n != 0 || wr_n != 0) begin errors++; $display("FAIL midrst_after got fin=%0d wr=%0d want 0/0", fin_n, wr_n); end
    endtask

    initial begin
        step();
        test_reset();
        test_single_write();
        test_burst();
        test_full();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
